// File: rtl/aes_axis_pkg.sv
// Shared definitions for the AES AXI-Stream latency bridge.
//   - Default block width and core latency.
//   - Packing of the sideband word {valid, tuser, tlast} carried beside the core.
//   - clog2 helper for counter and pointer widths.
package aes_axis_pkg;

    localparam int unsigned AES_BLOCK_W     = 128;
    localparam int unsigned DEFAULT_LATENCY = 21;
    localparam int unsigned DEFAULT_USER_W  = 8;

    // Sideband word layout, LSB first: tlast, tuser, then valid on top.
    localparam int unsigned SB_LAST_BIT = 0;
    localparam int unsigned SB_USER_LSB = 1;

    function automatic int unsigned sb_width(input int unsigned user_w);
        return user_w + 2;
    endfunction

    function automatic int unsigned sb_valid_bit(input int unsigned user_w);
        return user_w + 1;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/aes_axis_sync_fifo.sv
// Synchronous FIFO with output taken straight from the storage registers.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_wdata     write request and data (ignored when full unless popping)
//   i_pop               read request (ignored when empty)
//   o_rdata             head entry, valid while !o_empty
//   o_full, o_empty     occupancy flags
//   o_count             occupancy, 0..DEPTH
module aes_axis_sync_fifo
    import aes_axis_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [clog2(DEPTH):0]    o_count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so push-while-full is fine then.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/aes_axis_latency_bridge.sv
// AXI-Stream adapter around a fixed-latency, non-stallable AES core.
// tlast/tuser ride a sideband delay line matched to the core latency; results land
// in an output FIFO and a credit counter bounds admission so the FIFO never overflows.
// Ports:
//   aclk, areset                       clock, synchronous active-high reset
//   key_valid                          key schedule ready, gates admission
//   s_axis_t{data,user,last,valid,ready}   input stream
//   core_in_valid/data                 feed to core (combinational pass-through)
//   core_out_valid/data                core result
//   m_axis_t{data,user,last,valid,ready}   output stream
//   busy                               any block in flight or buffered
//   sync_err                           sticky core/sideband misalignment or overflow
module aes_axis_latency_bridge
    import aes_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AES_BLOCK_W,
    parameter int unsigned USER_WIDTH = DEFAULT_USER_W,
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  key_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  core_in_valid,
    output logic [DATA_WIDTH-1:0] core_in_data,
    input  logic                  core_out_valid,
    input  logic [DATA_WIDTH-1:0] core_out_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  sync_err
);

    localparam int unsigned CNT_W    = clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SB_W     = sb_width(USER_WIDTH);
    localparam int unsigned SB_VALID = sb_valid_bit(USER_WIDTH);
    localparam int unsigned FIFO_W   = DATA_WIDTH + USER_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]  r_credits;
    logic              r_sync_err;
    logic [SB_W-1:0]   r_sb [LATENCY];

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_mismatch;
    logic              w_overflow;
    logic [SB_W-1:0]   w_sb_in;
    logic [SB_W-1:0]   w_tail;
    logic              w_tail_valid;
    logic [FIFO_W-1:0] w_fifo_wdata;
    logic [FIFO_W-1:0] w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    // Admission and core feed.
    assign s_axis_tready = key_valid && (r_credits < CNT_FULL) && !areset;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign core_in_valid = w_accept;
    assign core_in_data  = s_axis_tdata;

    // Sideband line: bubbles carry valid=0 and tlast=0.
    always_comb begin
        w_sb_in                            = '0;
        w_sb_in[SB_VALID]                  = w_accept;
        w_sb_in[SB_USER_LSB +: USER_WIDTH] = s_axis_tuser;
        w_sb_in[SB_LAST_BIT]               = s_axis_tlast & w_accept;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_sb[0] <= w_sb_in;
            for (int k = 1; k < LATENCY; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    // Tail alignment: only a matched pair enters the FIFO.
    assign w_tail       = r_sb[LATENCY-1];
    assign w_tail_valid = w_tail[SB_VALID];
    assign w_push       = core_out_valid && w_tail_valid;
    assign w_mismatch   = core_out_valid != w_tail_valid;
    assign w_overflow   = w_push && w_fifo_full && !w_pop;
    assign w_fifo_wdata = {core_out_data, w_tail[SB_USER_LSB +: USER_WIDTH], w_tail[SB_LAST_BIT]};

    aes_axis_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign m_axis_tvalid = !w_fifo_empty && !areset;
    assign w_pop         = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = w_fifo_rdata[FIFO_W-1 -: DATA_WIDTH];
    assign m_axis_tuser  = w_fifo_rdata[1 +: USER_WIDTH];
    assign m_axis_tlast  = w_fifo_rdata[0];

    // Credits cover every block between acceptance and output handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_credits  <= '0;
            r_sync_err <= 1'b0;
        end else begin
            unique case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits + CNT_ONE;
                2'b01:   r_credits <= r_credits - CNT_ONE;
                default: r_credits <= r_credits;
            endcase
            r_sync_err <= r_sync_err | w_mismatch | w_overflow;
        end
    end

    assign busy     = (r_credits != '0) && !areset;
    assign sync_err = r_sync_err && !areset;

    // Buffered blocks are always a subset of credited blocks.
    a_fifo_within_credits: assert property (
        @(posedge aclk) disable iff (areset) w_fifo_count <= r_credits);

endmodule

// File: tb/tb_aes_axis_latency_bridge.sv
module tb_aes_axis_latency_bridge;

    localparam int unsigned DW   = 128;
    localparam int unsigned UW   = 8;
    localparam int unsigned LAT  = 21;
    localparam int unsigned DEP  = 32;
    localparam logic [DW-1:0] CORE_X = 128'hA5A5_0F0F_3C3C_FF00_1234_5678_9ABC_DEF0;

    logic          aclk = 1'b0;
    logic          areset;
    logic          key_valid;
    logic [DW-1:0] s_tdata;
    logic [UW-1:0] s_tuser;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic          core_in_valid;
    logic [DW-1:0] core_in_data;
    logic          core_out_valid;
    logic [DW-1:0] core_out_data;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic          busy;
    logic          sync_err;

    aes_axis_latency_bridge #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEP)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .key_valid      (key_valid),
        .s_axis_tdata   (s_tdata),
        .s_axis_tuser   (s_tuser),
        .s_axis_tlast   (s_tlast),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .core_in_valid  (core_in_valid),
        .core_in_data   (core_in_data),
        .core_out_valid (core_out_valid),
        .core_out_data  (core_out_data),
        .m_axis_tdata   (m_tdata),
        .m_axis_tuser   (m_tuser),
        .m_axis_tlast   (m_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .busy           (busy),
        .sync_err       (sync_err)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Behavioural core: fixed latency, data XOR constant, reset with the bridge.
    logic [LAT-1:0] core_v;
    logic [DW-1:0]  core_d [LAT];
    logic           inj;
    always @(posedge aclk) begin
        if (areset) begin
            core_v <= '0;
        end else begin
            core_v    <= {core_v[LAT-2:0], core_in_valid};
            core_d[0] <= core_in_data ^ CORE_X;
            for (int k = 1; k < LAT; k++) core_d[k] <= core_d[k-1];
        end
    end
    assign core_out_valid = core_v[LAT-1] | inj;
    assign core_out_data  = core_d[LAT-1];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected beats recorded at acceptance, checked at output handshake.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;
    beat_t exp_q[$];
    int n_acc = 0;
    int n_out = 0;

    always @(negedge aclk) begin
        beat_t b;
        if (!areset) begin
            if (s_tvalid && s_tready) begin
                exp_q.push_back({s_tdata ^ CORE_X, s_tuser, s_tlast});
                n_acc++;
            end
            if (m_tvalid && m_tready) begin
                n_out++;
                check_val("out_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check_val("out_tdata", m_tdata, b.d);
                    check_val("out_tuser", DW'(m_tuser), DW'(b.u));
                    check_val("out_tlast", DW'(m_tlast), DW'(b.l));
                end
            end
        end
    end

    int last_acc_cyc;

    task automatic send(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
        bit ok = 1'b0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge aclk);
            if (s_tready) begin
                ok = 1'b1;
                last_acc_cyc = cyc;
            end
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        check_val("send_accepted", DW'(ok), DW'(1));
    endtask

    task automatic wait_outs(input int target, input int budget, input string tag);
        int c = 0;
        while (n_out < target && c < budget) begin
            @(posedge aclk);
            #2;
            c++;
        end
        check_val(tag, DW'(n_out), DW'(target));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            idx, base, lat_c, stale, sent, acc0;
        bit            pending;
        logic [DW-1:0] hold_d;
        logic [UW-1:0] hold_u;

        // Reset with valid input present: nothing may leak through.
        areset    = 1'b1;
        key_valid = 1'b1;
        s_tvalid  = 1'b1;
        s_tdata   = 128'hDEAD;
        s_tuser   = '0;
        s_tlast   = 1'b0;
        m_tready  = 1'b1;
        inj       = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_tready", DW'(s_tready), DW'(0));
        check_val("rst_core_in_valid", DW'(core_in_valid), DW'(0));
        check_val("rst_m_tvalid", DW'(m_tvalid), DW'(0));
        check_val("rst_busy", DW'(busy), DW'(0));
        check_val("rst_sync_err", DW'(sync_err), DW'(0));
        @(posedge aclk);
        #1;
        areset   = 1'b0;
        s_tvalid = 1'b0;

        // 1: four blocks, latency LAT+1 from first accept.
        send(128'h1, 8'h11, 1'b0);
        base = last_acc_cyc;
        send(128'h2, 8'h12, 1'b0);
        send(128'h3, 8'h13, 1'b0);
        send(128'h4, 8'h14, 1'b1);
        lat_c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (m_tvalid) begin
                lat_c = cyc - base;
                break;
            end
        end
        check_val("t1_latency", DW'(lat_c), DW'(22));
        wait_outs(4, 100, "t1_nout");
        check_val("t1_busy_after_last", DW'(busy), DW'(0));

        // 2: output stalled, 40 offered, exactly DEP admitted.
        m_tready = 1'b0;
        idx      = 0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 60 && idx < 40; c++) begin
            s_tdata = 128'h200 + DW'(idx);
            s_tuser = 8'(idx);
            s_tlast = (idx % 8 == 7);
            @(negedge aclk);
            if (s_tready) idx++;
            @(posedge aclk);
            #1;
        end
        check_val("t2_accepted", DW'(idx), DW'(32));
        @(negedge aclk);
        check_val("t2_tready_low", DW'(s_tready), DW'(0));
        check_val("t2_busy", DW'(busy), DW'(1));
        check_val("t2_m_tvalid", DW'(m_tvalid), DW'(1));
        hold_d = m_tdata;
        hold_u = m_tuser;
        repeat (3) @(negedge aclk);
        check_val("t2_hold_data", m_tdata, hold_d);
        check_val("t2_hold_user", DW'(m_tuser), DW'(hold_u));
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        base     = n_out;
        wait_outs(base + 32, 200, "t2_drained");
        check_val("t2_sync_err", DW'(sync_err), DW'(0));
        @(negedge aclk);
        check_val("t2_tready_back", DW'(s_tready), DW'(1));
        @(posedge aclk);
        #1;
        for (int i = 32; i < 40; i++) send(128'h200 + DW'(i), 8'(i), (i % 8 == 7));
        wait_outs(base + 40, 200, "t2_resumed");

        // 3: random valid 50% / ready 30%, 1000 blocks.
        base    = n_out;
        acc0    = n_acc;
        pending = 1'b0;
        sent    = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            if (!pending && $urandom_range(0, 1) == 1) begin
                s_tdata  = {$urandom, $urandom, $urandom, $urandom};
                s_tuser  = 8'($urandom);
                s_tlast  = 1'($urandom_range(0, 1));
                s_tvalid = 1'b1;
                pending  = 1'b1;
            end
            m_tready = ($urandom_range(0, 9) < 3);
            @(negedge aclk);
            if (pending && s_tready) begin
                pending = 1'b0;
                sent++;
            end
            @(posedge aclk);
            #1;
            if (!pending) s_tvalid = 1'b0;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        wait_outs(base + 1000, 500, "t3_all_out");
        check_val("t3_accepted", DW'(n_acc - acc0), DW'(1000));
        check_val("t3_queue_empty", DW'(exp_q.size()), DW'(0));
        check_val("t3_sync_err", DW'(sync_err), DW'(0));

        // 4: key_valid drops after 5 accepts; in-flight blocks still drain.
        base = n_out;
        for (int i = 0; i < 5; i++) send(128'h400 + DW'(i), 8'h40 + 8'(i), (i == 4));
        key_valid = 1'b0;
        s_tdata   = 128'h4FF;
        s_tvalid  = 1'b1;
        @(negedge aclk);
        check_val("t4_tready_drop", DW'(s_tready), DW'(0));
        acc0 = n_acc;
        repeat (30) @(negedge aclk);
        check_val("t4_no_admit", DW'(n_acc), DW'(acc0));
        @(posedge aclk);
        #1;
        s_tvalid  = 1'b0;
        wait_outs(base + 5, 50, "t4_drained");
        check_val("t4_busy", DW'(busy), DW'(0));
        key_valid = 1'b1;

        // 5: spurious core_out_valid on an idle bubble.
        @(posedge aclk);
        #1;
        inj = 1'b1;
        @(posedge aclk);
        #1;
        inj = 1'b0;
        @(negedge aclk);
        check_val("t5_sync_err_set", DW'(sync_err), DW'(1));
        check_val("t5_no_entry", DW'(m_tvalid), DW'(0));
        check_val("t5_busy", DW'(busy), DW'(0));
        repeat (5) @(negedge aclk);
        check_val("t5_sync_err_sticky", DW'(sync_err), DW'(1));

        // 6: reset with 5 buffered and 10 in flight.
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(128'h600 + DW'(i), 8'h60, 1'b0);
        repeat (25) @(posedge aclk);
        #1;
        for (int i = 5; i < 15; i++) send(128'h600 + DW'(i), 8'h61, 1'b0);
        @(negedge aclk);
        check_val("t6_buffered", DW'(m_tvalid), DW'(1));
        check_val("t6_busy_pre", DW'(busy), DW'(1));
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(negedge aclk);
        check_val("t6_rst_tready", DW'(s_tready), DW'(0));
        check_val("t6_rst_m_tvalid", DW'(m_tvalid), DW'(0));
        check_val("t6_rst_busy", DW'(busy), DW'(0));
        check_val("t6_rst_sync_err", DW'(sync_err), DW'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        @(negedge aclk);
        check_val("t6_post_busy", DW'(busy), DW'(0));
        check_val("t6_post_m_tvalid", DW'(m_tvalid), DW'(0));
        check_val("t6_post_sync_err", DW'(sync_err), DW'(0));
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        stale    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (m_tvalid) stale++;
        end
        check_val("t6_no_stale", DW'(stale), DW'(0));
        check_val("t6_sync_err_clean", DW'(sync_err), DW'(0));
        @(posedge aclk);
        #1;
        base = n_out;
        send(128'h7777, 8'h77, 1'b1);
        wait_outs(base + 1, 50, "t6_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/aes_axis_latency_bridge.md
Name: aes_axis_latency_bridge

Overview:
Parametrised AXI-Stream adapter between one AXIS slave/master pair and a fixed-latency, non-stallable AES pipeline (core run with its enable tied high).
- Carries tlast/tuser alongside each block through a sideband delay line.
- Lands core results in an output FIFO, so downstream backpressure never stalls the core.
- Limits admission with a credit counter, so the FIFO cannot overflow.
- One instance per direction (encrypt or decrypt). Successor to the fixed tlast shift-register scheme, which loses data under backpressure.

Parameters:
DATA_WIDTH, 128, AES block / tdata width
USER_WIDTH, 8, tuser sideband width (must be ≥1)
LATENCY, 21, core cycles from in_valid to out_valid (must be ≥1)
FIFO_DEPTH, 32, output FIFO entries; power of two; must be ≥ LATENCY+1 for full throughput
CNT_W, clog2(FIFO_DEPTH)+1, credit/occupancy counter width (derived, not overridden)

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
key_valid  in  1  core key schedule ready; admission gated by it
s_axis_tdata  in  DATA_WIDTH  input block
s_axis_tuser  in  USER_WIDTH  input sideband
s_axis_tlast  in  1  end of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
core_in_valid  out  1  block presented to core
core_in_data  out  DATA_WIDTH  data to core
core_out_valid  in  1  core result valid
core_out_data  in  DATA_WIDTH  core result
m_axis_tdata  out  DATA_WIDTH  output block
m_axis_tuser  out  USER_WIDTH  output sideband
m_axis_tlast  out  1  end of packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
busy  out  1  any block in flight or buffered
sync_err  out  1  sticky core/sideband misalignment flag

Behaviour:
Reset:
- areset is sampled on the aclk rising edge only.
- While asserted: s_axis_tready=0, core_in_valid=0, m_axis_tvalid=0, busy=0, sync_err=0; credits, FIFO pointers and sideband line cleared.
- Reset mid-operation discards all in-flight and buffered blocks. The core must be reset in the same cycle.

Admission:
- s_axis_tready = key_valid && credits < FIFO_DEPTH && !areset.
- tready must not depend on s_axis_tvalid.
- Accept = s_axis_tvalid && s_axis_tready.

Core feed:
- core_in_valid = accept; core_in_data = s_axis_tdata (combinational pass-through, zero added latency).

Sideband line:
- LATENCY-stage shift register of {valid, tuser, tlast}. It advances every cycle, unconditionally.
- Stage 0 loads {accept, tuser, tlast}. Non-accept cycles insert a bubble (valid=0, tlast forced 0).

Alignment:
- At the tail, core_out_valid and the tail valid bit must agree.
- Both 1: push {core_out_data, tail tuser, tail tlast} into the FIFO.
- Mismatch: set sync_err (sticky until reset) and push nothing.

FIFO:
- Synchronous, registered output; m_axis_tvalid is high when occupancy > 0.
- Minimum input-to-output latency is LATENCY+1 cycles: accept at cycle N → m_axis_tvalid at N+LATENCY+1 when the FIFO was empty.
- Simultaneous push and pop while full or empty is legal and preserves order.
- A push while full can only occur on core misbehaviour: drop the data and set sync_err.

Credits:
- Count of in-flight plus buffered blocks.
- +1 on accept, −1 on m_axis handshake; unchanged when both occur in the same cycle.
- Never exceeds FIFO_DEPTH.

busy = credits != 0.

key_valid deasserting mid-stream blocks new admission only; blocks already in flight drain and are delivered normally.

Throughput:
- One block per cycle sustained when m_axis_tready=1 and FIFO_DEPTH ≥ LATENCY+1.
- Otherwise admission stalls once credits reach FIFO_DEPTH.

Output holds m_axis_tdata/tuser/tlast stable while tvalid && !tready.

Decomposition:
Package aes_axis_pkg:
- AES_BLOCK_W=128
- DEFAULT_LATENCY=21
- clog2 function
- Sideband struct/packing constants {valid, tuser, tlast}

Sub-module aes_axis_sync_fifo (parametrised width/depth, registered output, full/empty/count) is instantiated once. The sideband line and credit counter stay in the top.

Test Plan:
- Reset, key_valid=1, send 4 blocks 0x…01–0x…04 with tlast on the 4th and m_axis_tready=1 (behavioural core: data XOR constant, LATENCY=21) → first m_axis_tvalid 22 cycles after first accept; 4 outputs in order; tlast only on the 4th; tuser preserved.
- m_axis_tready=0, stream 40 blocks with FIFO_DEPTH=32 → exactly 32 accepted; s_axis_tready low with credits=32. Then tready=1 → all 32 delivered in order, then admission resumes; no loss, sync_err=0.
- Random valid/ready (50%/30%), 1000 blocks, random tlast/tuser → scoreboard exact match of data, tuser and tlast; no duplicate or dropped beat.
- key_valid drops after 5 accepts → tready=0 next cycle; the 5 in-flight blocks still emerge; busy goes 0 after the last output handshake.
- Core model injects a spurious core_out_valid at one bubble → sync_err=1 the following cycle and stays 1; no extra FIFO entry.
- areset pulsed with 10 blocks in flight and 5 buffered → outputs at reset values next cycle; busy=0; no stale block emerges after reset.
